// File: rtl/rom_fetch_arbiter.sv
// ROM sequencer: PC-driven fetch into a prefetch FIFO, round-robin shared with a debug read port.
// Optional: MISALIGN_TRAP_EN traps misaligned redirects into a sticky err flag.
module rom_fetch_arbiter #(
  parameter int AW    = 9,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          if_valid,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          if_ready,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_data,
  output logic          busy,
  output logic          err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, RUN} st_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } fq_t;

  st_t           state;
  st_t           state_nx;
  logic [AW-1:0] pc;
  fq_t           mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic          last_dbg;
  logic          misalign;
  logic          pop;
  logic          flush;
  logic          fetch_want;
  logic          fetch_gnt;
  logic          dbg_ok;
  logic          dbg_take;
  logic          unused_bits;

  assign unused_bits = ^{redirect_pc[1:0], dbg_addr[1:0]};

`ifdef MISALIGN_TRAP_EN
  assign misalign = redirect_en & (|redirect_pc[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!misalign && start && !stop) state_nx = RUN;
      RUN:  if (stop || misalign) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  assign if_valid = (count != '0);
  assign if_instr = if_valid ? mem[rp].instr : '0;
  assign if_pc    = if_valid ? mem[rp].pc : '0;
  assign pop      = if_valid & if_ready;
  assign flush    = redirect_en | (busy & stop);
  assign dbg_ok   = dbg_req & ~reset;

  assign fetch_want = busy & ~reset & ~redirect_en & ~stop
                    & ((count < CW'(DEPTH)) | pop);

  // Contention goes to whichever side did not win last time.
  always_comb begin
    fetch_gnt = 1'b0;
    dbg_take  = 1'b0;
    unique case (1'b1)
      (fetch_want & dbg_ok): begin
        fetch_gnt = last_dbg;
        dbg_take  = ~last_dbg;
      end
      (fetch_want & ~dbg_ok): fetch_gnt = 1'b1;
      (~fetch_want & dbg_ok): dbg_take  = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr = dbg_take ? {dbg_addr[AW-1:2], 2'b00} : pc;

  always_ff @(posedge clk) begin
    if (fetch_gnt && !reset) mem[wp] <= '{pc: pc, instr: rom_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      last_dbg <= 1'b0;
      dbg_gnt  <= 1'b0;
      dbg_data <= '0;
    end else begin
      dbg_gnt <= dbg_take;
      if (dbg_take) dbg_data <= rom_data;
      if (fetch_gnt || dbg_take) last_dbg <= dbg_take;
      if (redirect_en && !misalign) pc <= {redirect_pc[AW-1:2], 2'b00};
      else if (fetch_gnt)           pc <= pc + AW'(4);
      if (flush) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else begin
        if (fetch_gnt) wp <= wp + 1'b1;
        if (pop)       rp <= rp + 1'b1;
        count <= count + CW'(fetch_gnt) - CW'(pop);
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)         err <= 1'b0;
    else if (misalign) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Randomized scoreboard bench for rom_fetch_arbiter against a queue-based reference model.
// Build with +define+MISALIGN_TRAP_EN to check the trapping variant.
module tb_rom_fetch_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic          redirect_en;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          if_ready;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_data;
  logic          busy;
  logic          err;

  rom_fetch_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_data(dbg_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] romb [512];

  function automatic logic [31:0] rw(input logic [8:0] a);
    rw = {romb[9'(a + 9'd3)], romb[9'(a + 9'd2)],
          romb[9'(a + 9'd1)], romb[a]};
  endfunction

  always_comb rom_data = rw(rom_addr);

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] w;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] dq[$];
  bit          m_run;
  bit          m_err;
  bit          m_last_dbg;
  int          m_pc;
  bit          mon_en = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one step per rising edge, using the inputs of that cycle.
  task automatic model_step();
    bit mis, pop, fw, fg, dg, trap;
    int a;
    ent_t e;
`ifdef MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    if (reset) begin
      m_run = 0; m_err = 0; m_pc = 0; m_last_dbg = 0;
      mq.delete();
      return;
    end
    mis = trap && redirect_en && (redirect_pc % 4 != 0);
    pop = (mq.size() > 0) && if_ready;
    fw  = m_run && !redirect_en && !stop && (mq.size() < DEPTH || pop);
    if (fw && dbg_req) begin
      dg = !m_last_dbg;
      fg = !dg;
    end else begin
      fg = fw;
      dg = dbg_req;
    end
    a = dg ? (int'(dbg_addr) / 4) * 4 : m_pc;
    if (dg) dq.push_back(rw(9'(a)));
    if (fg || dg) m_last_dbg = dg;
    if (redirect_en || (m_run && stop)) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (fg) begin
        e.pc = 9'(m_pc);
        e.w  = rw(9'(m_pc));
        mq.push_back(e);
      end
    end
    if (redirect_en && !mis) m_pc = (int'(redirect_pc) / 4) * 4;
    else if (fg)             m_pc = (m_pc + 4) % 512;
    if (mis) begin
      m_err = 1;
      m_run = 0;
    end else if (m_run) begin
      if (stop) m_run = 0;
    end else if (start && !stop) m_run = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("busy", 64'(busy), 64'(m_run));
      chk("err", 64'(err), 64'(m_err));
      chk("if_valid", 64'(if_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("if_pc", 64'(if_pc), 64'(mq[0].pc));
        chk("if_instr", 64'(if_instr), 64'(mq[0].w));
      end else begin
        chk("if_pc_empty", 64'(if_pc), 64'(0));
        chk("if_instr_empty", 64'(if_instr), 64'(0));
      end
      chk("dbg_gnt", 64'(dbg_gnt), 64'(dq.size() != 0));
      if (dq.size() != 0) begin
        if (dbg_gnt) chk("dbg_data", 64'(dbg_data), 64'(dq[0]));
        void'(dq.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) romb[i] = 8'($urandom);
    reset = 1; start = 0; stop = 0; redirect_en = 0; redirect_pc = '0;
    if_ready = 0; dbg_req = 0; dbg_addr = '0;
    tick(1);
    mon_en = 1;
    tick(2);
    reset = 0;
    tick(1);
    start = 1; if_ready = 1;
    tick(1);
    start = 0;
    tick(140);
    if_ready = 0;
    tick(5);
    if_ready = 1;
    tick(4);
    redirect_en = 1; redirect_pc = 9'h040;
    tick(1);
    redirect_en = 0;
    tick(6);
    dbg_req = 1; dbg_addr = 9'h010;
    tick(10);
    dbg_addr = 9'h013;
    tick(6);
    dbg_req = 0;
    stop = 1;
    tick(1);
    stop = 0;
    tick(1);
    dbg_req = 1; dbg_addr = 9'h020;
    tick(1);
    dbg_req = 0;
    tick(3);
    start = 1;
    tick(1);
    start = 0;
    tick(4);
    redirect_en = 1; redirect_pc = 9'h042;
    tick(1);
    redirect_en = 0;
    tick(6);
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom % 200) == 0;
      start       = ($urandom % 8) == 0;
      stop        = ($urandom % 40) == 0;
      redirect_en = ($urandom % 30) == 0;
      redirect_pc = 9'($urandom);
      if_ready    = ($urandom % 4) != 0;
      dbg_req     = ($urandom % 3) == 0;
      dbg_addr    = 9'($urandom);
      tick(1);
    end
    reset = 0; start = 0; stop = 0; redirect_en = 0; dbg_req = 0;
    if_ready = 1;
    tick(5);
    @(negedge clk);
    #1;
    chk("dbg_queue_drained", 64'(dq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
